adc_channel_averager: RTL and testbench
=======================================

Name: adc_channel_averager

Overview:
- Consumes each completed ADC122S021 conversion and builds per-channel block averages for channel 0 and channel 1.
- Input sample = 12-bit conversion word, its channel tag and a one-cycle valid pulse, taken from the ADC interface stage on its end-of-conversion cycle.
- Each channel averages 2^LOG2_AVG samples, then publishes a rounded 12-bit average, the block peak and a one-cycle ready pulse for the control/telemetry logic.
- Tags 2 and 3 are not valid on the two-channel part; those samples are counted and dropped.

Parameters:
- LOG2_AVG, 4, log2 of samples per average; legal range 0..8.
- DATA_W, 12, sample and average width.

Ports:
- X_512x96k_1024x48k_Clk  in  1  system clock; all logic rising-edge.
- X_Async_Reset_L  in  1  reset, asynchronous, active-low.
- X_Clear_pulse  in  1  synchronous clear of in-progress accumulation.
- X_Sample_Valid_pulse  in  1  one-cycle strobe; tag and data valid this cycle.
- X_Sample_Channel  in  2  channel tag of the sample.
- X_Sample_Data  in  DATA_W  unsigned conversion word.
- X_Ch0_Average_Word  out  DATA_W  latest channel-0 average.
- X_Ch1_Average_Word  out  DATA_W  latest channel-1 average.
- X_Ch0_Peak_Word  out  DATA_W  maximum sample of the latest channel-0 block.
- X_Ch1_Peak_Word  out  DATA_W  maximum sample of the latest channel-1 block.
- X_Ch0_Average_Ready_pulse  out  1  one-cycle strobe; new ch0 results are valid.
- X_Ch1_Average_Ready_pulse  out  1  one-cycle strobe; new ch1 results are valid.
- X_Ignored_Sample_Count  out  8  saturating count of samples tagged 2 or 3.

Behaviour:
- Reset, asynchronous and active-low. Clears to 0: every output, both accumulators, both sample counters, both running peaks and the ignored counter. Reset mid-block discards the partial block.
- Per-channel state (ch = 0, 1):
  - accumulator, width DATA_W+LOG2_AVG;
  - sample counter, width max(LOG2_AVG,1);
  - running peak, width DATA_W.
- Sample accepted: X_Sample_Valid_pulse=1, X_Sample_Channel=ch, X_Clear_pulse=0.
- Accepted sample, not the last of the block (counter != N-1, N = 2^LOG2_AVG):
  - acc <= acc + data;
  - cnt <= cnt + 1;
  - peak <= max(peak, data); the first sample of a block loads peak directly.
- Accepted sample that is the last of the block (counter == N-1; every sample when LOG2_AVG=0):
  - sum = acc + data;
  - average = (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG, i.e. round half up; no rounding term when LOG2_AVG=0;
  - average saturates at 2^DATA_W-1;
  - the average and max(peak, data) are registered into the output word and peak ports on the next edge;
  - the ready pulse asserts in that same cycle, for exactly one cycle;
  - acc, cnt and running peak return to 0.
- Latency: ready pulse and updated words appear 1 clock after the valid pulse of the final sample. Outputs hold between updates.
- Ready pulses otherwise 0. Each pulse depends only on its own channel.
- Samples arrive at most once per valid pulse. Back-to-back valid pulses on consecutive cycles are legal and fully processed. No back-pressure.
- Tag 2 or 3 with valid: the sample is ignored and X_Ignored_Sample_Count increments, saturating at 255. No channel state changes.
- X_Clear_pulse:
  - zeroes both accumulators, counters and running peaks;
  - output words, peaks, ready pulses and the ignored counter are not affected;
  - a clear in the same cycle as a valid pulse discards that sample and does not count it, even if tagged 2/3;
  - a ready pulse already scheduled from the previous cycle still fires.
- X_Sample_Data is unsigned; no sign handling.
- Accumulator never overflows: N × (2^DATA_W−1) fits in DATA_W+LOG2_AVG bits.

Test Plan:
- Reset, then 16 ch0 samples of 0x800 (LOG2_AVG=4) → one cycle after the 16th valid: X_Ch0_Average_Ready_pulse=1 for one cycle, X_Ch0_Average_Word=0x800, X_Ch0_Peak_Word=0x800; ch1 outputs stay 0.
- Interleaved tags 0,3,2,1 repeated 16 times; ch0 data=0x100, ch1 data=0x0FF → ch0 average 0x100, ch1 average 0x0FF, X_Ignored_Sample_Count=32.
- Rounding: 15 ch1 samples of 0x000 then one of 0x008 (sum 8) → average (8+8)>>4 = 0x001, peak 0x008. Repeat with final 0x007 → average 0x000.
- Saturation/extremes: 16 ch0 samples of 0xFFF → average 0xFFF, peak 0xFFF, no wrap. 300 tag-3 samples → ignored count stops at 0xFF.
- Clear: 10 ch0 samples of 0x400, clear asserted together with the 11th sample, then 16 samples of 0x200 → single ready pulse, average 0x200. Prior output words unchanged until that pulse.
- Async reset asserted mid-block after 8 ch1 samples of 0xA00, released, then 16 samples of 0x010 → average 0x010. All outputs read 0 immediately on reset assertion, with no clock needed.

Source files
------------

// File: rtl/adc_channel_averager.sv
// Two-channel block averager for ADC122S021 conversions.
// Publishes rounded averages, block peaks and ready strobes per channel.
module adc_channel_averager #(
  parameter int LOG2_AVG = 4,
  parameter int DATA_W   = 12
) (
  input  logic              X_512x96k_1024x48k_Clk,
  input  logic              X_Async_Reset_L,
  input  logic              X_Clear_pulse,
  input  logic              X_Sample_Valid_pulse,
  input  logic [1:0]        X_Sample_Channel,
  input  logic [DATA_W-1:0] X_Sample_Data,
  output logic [DATA_W-1:0] X_Ch0_Average_Word,
  output logic [DATA_W-1:0] X_Ch1_Average_Word,
  output logic [DATA_W-1:0] X_Ch0_Peak_Word,
  output logic [DATA_W-1:0] X_Ch1_Peak_Word,
  output logic              X_Ch0_Average_Ready_pulse,
  output logic              X_Ch1_Average_Ready_pulse,
  output logic [7:0]        X_Ignored_Sample_Count
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int RND_I = (LOG2_AVG > 0) ? (1 << (LOG2_AVG - 1)) : 0;
  localparam logic [ACC_W:0] RND = (ACC_W + 1)'(RND_I);

  logic              clk;
  logic              rst_n;

  assign clk   = X_512x96k_1024x48k_Clk;
  assign rst_n = X_Async_Reset_L;

  logic [ACC_W-1:0]  acc_q   [2];
  logic [ACC_W-1:0]  acc_d   [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic [DATA_W-1:0] pk_q    [2];
  logic [DATA_W-1:0] pk_d    [2];
  logic [DATA_W-1:0] avg_q   [2];
  logic [DATA_W-1:0] avg_d   [2];
  logic [DATA_W-1:0] opk_q   [2];
  logic [DATA_W-1:0] opk_d   [2];
  logic              rdy_q   [2];
  logic              rdy_d   [2];
  logic [7:0]        ign_q;
  logic [7:0]        ign_d;

  logic [ACC_W:0]    sum_w   [2];
  logic [ACC_W:0]    avg_w   [2];
  logic [DATA_W-1:0] pk_max  [2];
  logic              hit     [2];
  logic              last    [2];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      acc_d[ch] = acc_q[ch];
      cnt_d[ch] = cnt_q[ch];
      pk_d[ch]  = pk_q[ch];
      avg_d[ch] = avg_q[ch];
      opk_d[ch] = opk_q[ch];
      rdy_d[ch] = 1'b0;

      sum_w[ch] = {1'b0, acc_q[ch]} + (ACC_W + 1)'(X_Sample_Data);
      avg_w[ch] = (sum_w[ch] + RND) >> LOG2_AVG;

      // First sample of a block overrides whatever the peak held.
      if ((cnt_q[ch] == '0) || (X_Sample_Data > pk_q[ch])) begin
        pk_max[ch] = X_Sample_Data;
      end else begin
        pk_max[ch] = pk_q[ch];
      end

      hit[ch]  = X_Sample_Valid_pulse && !X_Clear_pulse &&
                 (X_Sample_Channel == 2'(ch));
      last[ch] = (LOG2_AVG == 0) || (cnt_q[ch] == '1);

      if (X_Clear_pulse) begin
        acc_d[ch] = '0;
        cnt_d[ch] = '0;
        pk_d[ch]  = '0;
      end else if (hit[ch]) begin
        if (last[ch]) begin
          if (|avg_w[ch][ACC_W:DATA_W]) begin
            avg_d[ch] = '1;
          end else begin
            avg_d[ch] = avg_w[ch][DATA_W-1:0];
          end
          opk_d[ch] = pk_max[ch];
          rdy_d[ch] = 1'b1;
          acc_d[ch] = '0;
          cnt_d[ch] = '0;
          pk_d[ch]  = '0;
        end else begin
          acc_d[ch] = acc_q[ch] + ACC_W'(X_Sample_Data);
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          pk_d[ch]  = pk_max[ch];
        end
      end
    end
  end

  // Tags 2/3 only count when no clear discards them.
  always_comb begin
    ign_d = ign_q;
    if (X_Sample_Valid_pulse && !X_Clear_pulse &&
        X_Sample_Channel[1] && (ign_q != 8'hFF)) begin
      ign_d = ign_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        acc_q[ch] <= '0;
        cnt_q[ch] <= '0;
        pk_q[ch]  <= '0;
        avg_q[ch] <= '0;
        opk_q[ch] <= '0;
        rdy_q[ch] <= 1'b0;
      end
      ign_q <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        acc_q[ch] <= acc_d[ch];
        cnt_q[ch] <= cnt_d[ch];
        pk_q[ch]  <= pk_d[ch];
        avg_q[ch] <= avg_d[ch];
        opk_q[ch] <= opk_d[ch];
        rdy_q[ch] <= rdy_d[ch];
      end
      ign_q <= ign_d;
    end
  end

  assign X_Ch0_Average_Word        = avg_q[0];
  assign X_Ch1_Average_Word        = avg_q[1];
  assign X_Ch0_Peak_Word           = opk_q[0];
  assign X_Ch1_Peak_Word           = opk_q[1];
  assign X_Ch0_Average_Ready_pulse = rdy_q[0];
  assign X_Ch1_Average_Ready_pulse = rdy_q[1];
  assign X_Ignored_Sample_Count    = ign_q;

endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed bench for adc_channel_averager (LOG2_AVG=4, DATA_W=12).
// Vector table for block averages plus hand sequences for corner cases.
module tb_adc_channel_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic [1:0]  chn = 2'd0;
  logic [11:0] dat = 12'd0;
  logic [11:0] avg0, avg1, pk0, pk1;
  logic        rdy0, rdy1;
  logic [7:0]  ign;

  int checks = 0;
  int errors = 0;
  int np0 = 0;
  int np1 = 0;

  always #5 clk = ~clk;

  adc_channel_averager dut (
    .X_512x96k_1024x48k_Clk    (clk),
    .X_Async_Reset_L           (rst_n),
    .X_Clear_pulse             (clr),
    .X_Sample_Valid_pulse      (vld),
    .X_Sample_Channel          (chn),
    .X_Sample_Data             (dat),
    .X_Ch0_Average_Word        (avg0),
    .X_Ch1_Average_Word        (avg1),
    .X_Ch0_Peak_Word           (pk0),
    .X_Ch1_Peak_Word           (pk1),
    .X_Ch0_Average_Ready_pulse (rdy0),
    .X_Ch1_Average_Ready_pulse (rdy1),
    .X_Ignored_Sample_Count    (ign)
  );

  always @(negedge clk) begin
    if (rdy0) np0 = np0 + 1;
    if (rdy1) np1 = np1 + 1;
  end

  typedef struct {
    logic [1:0]  ch;
    int          n;
    logic [11:0] d;
    logic [11:0] dl;
    logic [11:0] ea;
    logic [11:0] ep;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [11:0] d,
                      input logic cl);
    vld = 1'b1;
    chn = c;
    dat = d;
    clr = cl;
    @(posedge clk);
    #1;
    vld = 1'b0;
    clr = 1'b0;
    dat = 12'd0;
    chn = 2'd0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int p0, p1;
    p0 = np0;
    p1 = np1;
    for (int k = 0; k < vecs[i].n - 1; k++) send(vecs[i].ch, vecs[i].d, 1'b0);
    send(vecs[i].ch, vecs[i].dl, 1'b0);
    if (vecs[i].ch == 2'd0) begin
      chk($sformatf("v%0d rdy0", i), rdy0, 1);
      chk($sformatf("v%0d rdy1", i), rdy1, 0);
      chk($sformatf("v%0d avg0", i), avg0, vecs[i].ea);
      chk($sformatf("v%0d pk0", i), pk0, vecs[i].ep);
    end else begin
      chk($sformatf("v%0d rdy1", i), rdy1, 1);
      chk($sformatf("v%0d rdy0", i), rdy0, 0);
      chk($sformatf("v%0d avg1", i), avg1, vecs[i].ea);
      chk($sformatf("v%0d pk1", i), pk1, vecs[i].ep);
    end
    idle();
    chk($sformatf("v%0d pulse_end", i), rdy0 | rdy1, 0);
    chk($sformatf("v%0d npulse0", i), np0 - p0, (vecs[i].ch == 2'd0) ? 1 : 0);
    chk($sformatf("v%0d npulse1", i), np1 - p1, (vecs[i].ch == 2'd1) ? 1 : 0);
  endtask

  initial begin
    int p0, p1;

    vecs[0] = '{2'd0, 16, 12'h800, 12'h800, 12'h800, 12'h800};
    vecs[1] = '{2'd1, 16, 12'h000, 12'h008, 12'h001, 12'h008};
    vecs[2] = '{2'd1, 16, 12'h000, 12'h007, 12'h000, 12'h007};
    vecs[3] = '{2'd0, 16, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    vecs[4] = '{2'd1, 16, 12'h010, 12'h01F, 12'h011, 12'h01F};
    vecs[5] = '{2'd0, 16, 12'h001, 12'h000, 12'h001, 12'h001};

    #22;
    chk("rst avg0", avg0, 0);
    chk("rst pk1", pk1, 0);
    chk("rst rdy", rdy0 | rdy1, 0);
    chk("rst ign", ign, 0);
    rst_n = 1'b1;
    idle();

    run_vec(0);
    chk("v0 avg1 idle", avg1, 0);
    chk("v0 pk1 idle", pk1, 0);
    for (int i = 1; i < 6; i++) run_vec(i);
    chk("ign after table", ign, 0);

    // Interleaved tags 0,3,2,1
    p0 = np0;
    p1 = np1;
    for (int r = 0; r < 16; r++) begin
      send(2'd0, 12'h100, 1'b0);
      send(2'd3, 12'hABC, 1'b0);
      send(2'd2, 12'h123, 1'b0);
      send(2'd1, 12'h0FF, 1'b0);
    end
    chk("il rdy1", rdy1, 1);
    chk("il avg0", avg0, 12'h100);
    chk("il avg1", avg1, 12'h0FF);
    chk("il pk0", pk0, 12'h100);
    chk("il pk1", pk1, 12'h0FF);
    chk("il ign", ign, 32);
    idle();
    chk("il npulse0", np0 - p0, 1);
    chk("il npulse1", np1 - p1, 1);

    // Clear alongside a tag-3 sample: not counted
    send(2'd3, 12'h555, 1'b1);
    chk("clr tag3 ign", ign, 32);

    // Clear mid-block
    p0 = np0;
    for (int k = 0; k < 10; k++) send(2'd0, 12'h400, 1'b0);
    send(2'd0, 12'h400, 1'b1);
    chk("clr hold avg0", avg0, 12'h100);
    chk("clr hold pk0", pk0, 12'h100);
    for (int k = 0; k < 15; k++) send(2'd0, 12'h200, 1'b0);
    chk("clr no early pulse", np0 - p0, 0);
    chk("clr prefinal avg0", avg0, 12'h100);
    send(2'd0, 12'h200, 1'b0);
    chk("clr rdy0", rdy0, 1);
    chk("clr avg0", avg0, 12'h200);
    chk("clr pk0", pk0, 12'h200);
    idle();
    chk("clr npulse0", np0 - p0, 1);

    // Ignored counter saturation
    for (int k = 0; k < 300; k++) send(2'd3, 12'h0, 1'b0);
    chk("ign sat", ign, 255);
    chk("ign sat avg1", avg1, 12'h0FF);

    // Async reset mid-block
    for (int k = 0; k < 8; k++) send(2'd1, 12'hA00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst avg0", avg0, 0);
    chk("arst avg1", avg1, 0);
    chk("arst pk0", pk0, 0);
    chk("arst pk1", pk1, 0);
    chk("arst ign", ign, 0);
    #2;
    rst_n = 1'b1;
    idle();
    p1 = np1;
    for (int k = 0; k < 16; k++) send(2'd1, 12'h010, 1'b0);
    chk("arst rdy1", rdy1, 1);
    chk("arst new avg1", avg1, 12'h010);
    chk("arst new pk1", pk1, 12'h010);
    idle();
    chk("arst npulse1", np1 - p1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
